arm_pipelined_data_memory_responder: RTL and testbench

//  Memory-side responder for the Memory-stage data port of the pipelined ARM datapath.
//  - Accepts one load/store request at a time over a valid/ready handshake.
//  - Returns a response a fixed Latency cycles after acceptance.
//  - Drives o_Busy so the hazard unit stalls the pipeline until the response arrives.
//  - Supports word (LDR/STR) and byte (LDRB/STRB) accesses; little-endian lane order.

---
 rtl/arm_pipelined_data_memory_responder_if.sv | 26 ++
 rtl/arm_pipelined_data_memory_responder.sv | 161 ++++++++++++++++
 tb/tb_arm_pipelined_data_memory_responder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/arm_pipelined_data_memory_responder_if.sv
// Request/response bus between the Memory-stage data port and its memory responder.
// Signal names follow the responder's point of view (i_ driven by the pipeline, o_ by the responder).
interface arm_pipelined_data_memory_responder_if #(
  parameter int BusWidth = 32
);
  logic                i_ReqValid;
  logic                o_ReqReady;
  logic                i_WriteEnable;
  logic                i_ByteAccess;
  logic [BusWidth-1:0] i_Address;
  logic [BusWidth-1:0] i_WriteData;
  logic                o_RespValid;
  logic [BusWidth-1:0] o_ReadData;
  logic                o_Busy;
  logic                o_Fault;

  modport master (
    output i_ReqValid, i_WriteEnable, i_ByteAccess, i_Address, i_WriteData,
    input  o_ReqReady, o_RespValid, o_ReadData, o_Busy, o_Fault
  );

  modport slave (
    input  i_ReqValid, i_WriteEnable, i_ByteAccess, i_Address, i_WriteData,
    output o_ReqReady, o_RespValid, o_ReadData, o_Busy, o_Fault
  );
endinterface

// File: rtl/arm_pipelined_data_memory_responder.sv
// Fixed-latency word/byte data memory for the pipelined ARM Memory stage (Latency legal range 1..15).
// Optional feature: define ARM_DMEM_ALIGN_CHECK_EN to fault misaligned word accesses.
module arm_pipelined_data_memory_responder #(
  parameter int BusWidth  = 32,
  parameter int AddrWidth = 10,
  parameter int Latency   = 2
) (
  input  logic clk,
  input  logic reset,
  arm_pipelined_data_memory_responder_if.slave bus
);

  localparam int Depth = 2 ** AddrWidth;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t r_State;
  state_t w_NextState;
  logic [3:0] r_Count;
  logic [3:0] w_NextCount;
  logic w_ReqReady;
  logic w_Accept;
  logic w_EnterResp;
  logic w_RespValid;

  logic [BusWidth-1:0] r_Addr;
  logic [BusWidth-1:0] r_WData;
  logic r_We;
  logic r_Byte;

  logic [BusWidth-1:0] w_CAddr;
  logic [BusWidth-1:0] w_CWData;
  logic w_CWe;
  logic w_CByte;
  logic w_CFault;
  logic [AddrWidth-1:0] w_CIdx;
  logic [1:0] w_CLane;
  logic [BusWidth-1:0] w_CWord;
  logic [7:0] w_CByteData;
  logic w_unusedAddrBits;

  logic [BusWidth-1:0] r_Mem [Depth];
  logic [BusWidth-1:0] r_ReadData;
  logic r_Fault;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_State <= ST_IDLE;
      r_Count <= '0;
    end else begin
      r_State <= w_NextState;
      r_Count <= w_NextCount;
    end
  end

  // RESP accepts like IDLE so back-to-back requests issue every Latency cycles.
  always_comb begin
    w_NextState = r_State;
    w_NextCount = r_Count;
    w_EnterResp = 1'b0;
    w_ReqReady  = (r_State == ST_IDLE) || (r_State == ST_RESP);
    w_Accept    = bus.i_ReqValid && w_ReqReady;
    case (r_State)
      ST_IDLE, ST_RESP: begin
        if (w_Accept) begin
          if (Latency == 1) begin
            w_NextState = ST_RESP;
            w_EnterResp = 1'b1;
          end else begin
            w_NextState = ST_WAIT;
            w_NextCount = 4'(Latency - 1);
          end
        end else begin
          w_NextState = ST_IDLE;
        end
      end
      ST_WAIT: begin
        w_NextCount = r_Count - 4'd1;
        if (r_Count == 4'd1) begin
          w_NextState = ST_RESP;
          w_EnterResp = 1'b1;
        end
      end
      default: begin
        w_NextState = ST_IDLE;
        w_NextCount = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_Addr  <= '0;
      r_WData <= '0;
      r_We    <= 1'b0;
      r_Byte  <= 1'b0;
    end else if (w_Accept) begin
      r_Addr  <= bus.i_Address;
      r_WData <= bus.i_WriteData;
      r_We    <= bus.i_WriteEnable;
      r_Byte  <= bus.i_ByteAccess;
    end
  end

  // With Latency 1 the commit edge is the accept edge, so the live request is used directly.
  assign w_CAddr  = (Latency == 1) ? bus.i_Address     : r_Addr;
  assign w_CWData = (Latency == 1) ? bus.i_WriteData   : r_WData;
  assign w_CWe    = (Latency == 1) ? bus.i_WriteEnable : r_We;
  assign w_CByte  = (Latency == 1) ? bus.i_ByteAccess  : r_Byte;

  assign w_CIdx           = w_CAddr[AddrWidth+1:2];
  assign w_CLane          = w_CAddr[1:0];
  assign w_unusedAddrBits = ^w_CAddr[BusWidth-1:AddrWidth+2];
  assign w_CWord          = r_Mem[w_CIdx];
  assign w_CByteData      = w_CWord[{w_CLane, 3'b000} +: 8];

`ifdef ARM_DMEM_ALIGN_CHECK_EN
  assign w_CFault = ~w_CByte & (w_CLane != 2'b00);
`else
  assign w_CFault = 1'b0;
`endif

  // Array is never cleared; reset only blocks a commit that coincides with it.
  always_ff @(posedge clk) begin
    if (!reset && w_EnterResp && w_CWe && !w_CFault) begin
      if (w_CByte) begin
        r_Mem[w_CIdx][{w_CLane, 3'b000} +: 8] <= w_CWData[7:0];
      end else begin
        r_Mem[w_CIdx] <= w_CWData;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ReadData <= '0;
      r_Fault    <= 1'b0;
    end else if (w_EnterResp) begin
      r_Fault <= w_CFault;
      if (w_CWe || w_CFault) begin
        r_ReadData <= '0;
      end else if (w_CByte) begin
        r_ReadData <= {{(BusWidth-8){1'b0}}, w_CByteData};
      end else begin
        r_ReadData <= w_CWord;
      end
    end
  end

  assign w_RespValid     = (r_State == ST_RESP);
  assign bus.o_ReqReady  = w_ReqReady;
  assign bus.o_RespValid = w_RespValid;
  assign bus.o_ReadData  = w_RespValid ? r_ReadData : '0;
  assign bus.o_Fault     = w_RespValid & r_Fault;
  assign bus.o_Busy      = (bus.i_ReqValid & ~w_RespValid) | (r_State == ST_WAIT);

endmodule

// File: tb/tb_arm_pipelined_data_memory_responder.sv
// Scoreboard bench: one responder at Latency 2 and one at Latency 1, checked by negedge monitors.
module tb_arm_pipelined_data_memory_responder;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  arm_pipelined_data_memory_responder_if #(.BusWidth(32)) bus2 ();
  arm_pipelined_data_memory_responder_if #(.BusWidth(32)) bus1 ();

  arm_pipelined_data_memory_responder #(.BusWidth(32), .AddrWidth(10), .Latency(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  arm_pipelined_data_memory_responder #(.BusWidth(32), .AddrWidth(10), .Latency(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  typedef struct {
    logic [31:0] data;
    logic        fault;
    longint      t;
  } exp_t;

  exp_t q2[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;
  bit monitorOn = 1'b0;
  bit b2bBusyCheck = 1'b0;

`ifdef ARM_DMEM_ALIGN_CHECK_EN
  localparam bit AlignOn = 1'b1;
`else
  localparam bit AlignOn = 1'b0;
`endif

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, actual, expected, $time);
    end
  endtask

  // Latency-2 monitor: responses are popped and matched on data, fault and arrival time.
  always @(negedge clk) begin
    exp_t e;
    if (monitorOn) begin
      if (q2.size() > 0 && $time > q2[0].t) begin
        checkOutput("L2 missed response time", $time, 64'(q2[0].t));
        void'(q2.pop_front());
      end
      if (bus2.o_RespValid === 1'b1) begin
        if (q2.size() == 0) begin
          checkOutput("L2 unexpected response", 64'd1, 64'd0);
        end else begin
          e = q2.pop_front();
          checkOutput("L2 read data", {32'b0, bus2.o_ReadData}, {32'b0, e.data});
          checkOutput("L2 fault", {63'b0, bus2.o_Fault}, {63'b0, e.fault});
          checkOutput("L2 response time", $time, 64'(e.t));
        end
      end else begin
        checkOutput("L2 idle read data", {32'b0, bus2.o_ReadData}, 64'd0);
        checkOutput("L2 idle fault", {63'b0, bus2.o_Fault}, 64'd0);
      end
      if (b2bBusyCheck) begin
        checkOutput("L2 busy", {63'b0, bus2.o_Busy}, {63'b0, ~bus2.o_RespValid});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (monitorOn) begin
      if (q1.size() > 0 && $time > q1[0].t) begin
        checkOutput("L1 missed response time", $time, 64'(q1[0].t));
        void'(q1.pop_front());
      end
      if (bus1.o_RespValid === 1'b1) begin
        if (q1.size() == 0) begin
          checkOutput("L1 unexpected response", 64'd1, 64'd0);
        end else begin
          e = q1.pop_front();
          checkOutput("L1 read data", {32'b0, bus1.o_ReadData}, {32'b0, e.data});
          checkOutput("L1 fault", {63'b0, bus1.o_Fault}, {63'b0, e.fault});
          checkOutput("L1 response time", $time, 64'(e.t));
        end
      end else begin
        checkOutput("L1 idle read data", {32'b0, bus1.o_ReadData}, 64'd0);
      end
    end
  end

  // Issues one request and waits (bounded) for its accept edge; hold keeps i_ReqValid high afterwards.
  task automatic applyStimulus(input int which, input logic we, input logic byteAcc,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expData, input logic expFault,
                               input bit hold, input bit expectResp);
    exp_t e;
    bit ready;
    ready = 1'b0;
    if (which == 2) begin
      bus2.i_ReqValid = 1'b1; bus2.i_WriteEnable = we; bus2.i_ByteAccess = byteAcc;
      bus2.i_Address = addr; bus2.i_WriteData = wdata;
    end else begin
      bus1.i_ReqValid = 1'b1; bus1.i_WriteEnable = we; bus1.i_ByteAccess = byteAcc;
      bus1.i_Address = addr; bus1.i_WriteData = wdata;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ready = (which == 2) ? bus2.o_ReqReady : bus1.o_ReqReady;
      if (ready) break;
    end
    if (!ready) begin
      checkOutput("request accept timeout", 64'd0, 64'd1);
    end else if (expectResp) begin
      e.data  = expData;
      e.fault = expFault;
      e.t     = longint'($time) + ((which == 2) ? 20 : 10);
      if (which == 2) q2.push_back(e);
      else q1.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      if (which == 2) bus2.i_ReqValid = 1'b0;
      else bus1.i_ReqValid = 1'b0;
    end
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 40 && (q1.size() > 0 || q2.size() > 0); i++) @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    bus2.i_ReqValid = 1'b0;
    bus1.i_ReqValid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset L2 RespValid", {63'b0, bus2.o_RespValid}, 64'd0);
    checkOutput("reset L2 ReadData", {32'b0, bus2.o_ReadData}, 64'd0);
    checkOutput("reset L2 Fault", {63'b0, bus2.o_Fault}, 64'd0);
    checkOutput("reset L2 ReqReady", {63'b0, bus2.o_ReqReady}, 64'd1);
    checkOutput("reset L2 Busy", {63'b0, bus2.o_Busy}, 64'd0);
    checkOutput("reset L1 RespValid", {63'b0, bus1.o_RespValid}, 64'd0);
    checkOutput("reset L1 ReqReady", {63'b0, bus1.o_ReqReady}, 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    monitorOn = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    bus2.i_ReqValid = 1'b0; bus2.i_WriteEnable = 1'b0; bus2.i_ByteAccess = 1'b0;
    bus2.i_Address = '0; bus2.i_WriteData = '0;
    bus1.i_ReqValid = 1'b0; bus1.i_WriteEnable = 1'b0; bus1.i_ByteAccess = 1'b0;
    bus1.i_Address = '0; bus1.i_WriteData = '0;
    @(posedge clk);
    #1;
    resetDut();

    // Word store then load, Latency 2
    applyStimulus(2, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(2, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
    waitIdle();

    // Byte lane merge and zero-extended byte loads
    applyStimulus(2, 1'b1, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(2, 1'b1, 1'b1, 32'h13, 32'hFFFFFFA5, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(2, 1'b0, 1'b0, 32'h10, 32'h0, 32'hA5223344, 1'b0, 1'b0, 1'b1);
    applyStimulus(2, 1'b0, 1'b1, 32'h13, 32'h0, 32'h000000A5, 1'b0, 1'b0, 1'b1);
    applyStimulus(2, 1'b0, 1'b1, 32'h11, 32'h0, 32'h00000033, 1'b0, 1'b0, 1'b1);
    waitIdle();

    // Four back-to-back requests with i_ReqValid held high
    b2bBusyCheck = 1'b1;
    applyStimulus(2, 1'b1, 1'b0, 32'h40, 32'h0BADF00D, 32'h0, 1'b0, 1'b1, 1'b1);
    applyStimulus(2, 1'b1, 1'b0, 32'h44, 32'hCAFEBABE, 32'h0, 1'b0, 1'b1, 1'b1);
    applyStimulus(2, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0BADF00D, 1'b0, 1'b1, 1'b1);
    applyStimulus(2, 1'b0, 1'b0, 32'h44, 32'h0, 32'hCAFEBABE, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    b2bBusyCheck = 1'b0;
    waitIdle();

    // Reset during WAIT drops the pending store
    applyStimulus(2, 1'b1, 1'b0, 32'h20, 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b1);
    waitIdle();
    applyStimulus(2, 1'b1, 1'b0, 32'h20, 32'h00000005, 32'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset drop RespValid", {63'b0, bus2.o_RespValid}, 64'd0);
    @(posedge clk);
    #1;
    applyStimulus(2, 1'b0, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0, 1'b0, 1'b1);
    waitIdle();

    // Misaligned word store and loads
    applyStimulus(2, 1'b1, 1'b0, 32'h22, 32'hFFFFFFFF, 32'h0, AlignOn, 1'b0, 1'b1);
    applyStimulus(2, 1'b0, 1'b0, 32'h20, 32'h0, AlignOn ? 32'h12345678 : 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
    applyStimulus(2, 1'b0, 1'b0, 32'h22, 32'h0, AlignOn ? 32'h0 : 32'hFFFFFFFF, AlignOn, 1'b0, 1'b1);
    waitIdle();

    // Latency 1: next-cycle response, address aliasing, back-to-back byte store then load
    applyStimulus(1, 1'b1, 1'b0, 32'h0010, 32'h13579BDF, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 1'b0, 32'h1010, 32'h0, 32'h13579BDF, 1'b0, 1'b0, 1'b1);
    waitIdle();
    applyStimulus(1, 1'b1, 1'b1, 32'h1011, 32'h00000077, 32'h0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1, 1'b0, 1'b0, 32'h0010, 32'h0, 32'h135777DF, 1'b0, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 1'b1, 32'h0011, 32'h0, 32'h00000077, 1'b0, 1'b0, 1'b1);
    waitIdle();

    checkOutput("L2 scoreboard drained", 64'(q2.size()), 64'd0);
    checkOutput("L1 scoreboard drained", 64'(q1.size()), 64'd0);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog");
  end

endmodule
